capture_sequencer: RTL and testbench
====================================

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter pCOUNT_WIDTH, default 16: width of the capture-count and timeout-count fields.
REQ-002 Parameter pTIMEOUT_WIDTH, default 32: width of the trigger-timeout counter, in clk_usb cycles.
REQ-003 clk_usb  in  1  clock; reset is synchronous, active-high.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start_i  in  1  one-cycle pulse that begins a batch.
REQ-006 abort_i  in  1  one-cycle pulse that ends a batch immediately.
REQ-007 num_captures_i  in  pCOUNT_WIDTH  captures per batch; 0 means continuous until abort.
REQ-008 timeout_i  in  pTIMEOUT_WIDTH  trigger wait limit in cycles; 0 disables the timeout.
REQ-009 armed_i  in  1  arm status from the trigger unit, already synchronized to clk_usb.
REQ-010 capture_done_i  in  1  one-cycle pulse when a capture completes, already synchronized.
REQ-011 readout_done_i  in  1  one-cycle pulse when the host has drained the capture FIFO.
REQ-012 arm_o  out  1  level arm request to the trigger unit.
REQ-013 trigger_now_o  out  1  one-cycle forced-trigger pulse.
REQ-014 busy_o  out  1  high in every state except IDLE.
REQ-015 capture_count_o  out  pCOUNT_WIDTH  captures completed in the current batch.
REQ-016 timeout_count_o  out  pCOUNT_WIDTH  forced triggers issued in the current batch.
REQ-017 done_o  out  1  one-cycle pulse when a batch ends normally.
REQ-018 aborted_o  out  1  sticky flag set on abort; cleared by start_i.

Function
REQ-019 The state machine SHALL have the states IDLE, ARM, WAIT_ARMED, WAIT_TRIG, WAIT_READ and FINISH.
REQ-020 IDLE: start_i SHALL clear both counters and aborted_o, then go to ARM on the next cycle.
REQ-021 ARM: arm_o SHALL assert, then go to WAIT_ARMED.
REQ-022 WAIT_ARMED: armed_i high SHALL go to WAIT_TRIG and load the timeout counter with timeout_i.
REQ-023 Once asserted, arm_o SHALL stay high through WAIT_ARMED and WAIT_TRIG, and deassert on entry to WAIT_READ.
REQ-024 WAIT_TRIG: capture_done_i SHALL increment capture_count_o and go to WAIT_READ.
REQ-025 WAIT_TRIG with timeout_i nonzero: the timeout counter SHALL decrement each cycle.
REQ-026 When the timeout counter reaches 1, trigger_now_o SHALL pulse for exactly one cycle and timeout_count_o SHALL increment.
REQ-027 After a forced trigger, the block SHALL remain in WAIT_TRIG and wait for capture_done_i.
REQ-028 At most one forced trigger SHALL be issued per capture.
REQ-029 WAIT_READ: readout_done_i SHALL go to FINISH if capture_count_o equals num_captures_i (nonzero), otherwise to ARM.
REQ-030 FINISH: done_o SHALL pulse for one cycle, then return to IDLE.
REQ-031 The first forced-trigger pulse SHALL occur exactly timeout_i cycles after entry to WAIT_TRIG.
REQ-032 abort_i in any non-IDLE state SHALL, on the next cycle: enter IDLE, drop arm_o, set aborted_o, and leave done_o unpulsed.
REQ-033 abort_i takes priority over every simultaneous event.
REQ-034 start_i while busy SHALL be ignored.
REQ-035 start_i and abort_i together in IDLE: start_i wins.
REQ-036 capture_done_i in WAIT_TRIG in the same cycle the timeout expires: the capture SHALL win and trigger_now_o SHALL stay low.
REQ-037 capture_done_i or readout_done_i outside its consuming state SHALL be ignored.
REQ-038 capture_count_o and timeout_count_o SHALL saturate at all-ones, never wrap; continuous mode keeps running after saturation.
REQ-039 Every output SHALL be registered.

Reset
REQ-040 On reset: state IDLE; arm_o, trigger_now_o, busy_o, done_o and aborted_o all 0.
REQ-041 On reset: capture_count_o, timeout_count_o and the timeout counter all 0.
REQ-042 Reset mid-batch SHALL behave as abort, except that aborted_o stays 0.

Configuration
REQ-043 Macro CAPTURE_SEQUENCER_AUTO_TRIGGER_EN defined: the timeout and forced-trigger logic (REQ-025 to REQ-028, REQ-031) SHALL be built in.
REQ-044 Macro undefined: timeout_i is ignored, trigger_now_o and timeout_count_o are tied to 0, and WAIT_TRIG waits indefinitely.

Structure
REQ-045 The shared package SHALL hold the state encoding constants and the default widths.
REQ-046 The timeout down-counter SHALL be a sub-module, capseq_timer, instantiated only when the macro is defined.

Verification
REQ-047 num_captures_i=3, timeout 0; capture_done_i then readout_done_i three times: arm_o asserts three times, capture_count_o=3, one done_o pulse.
REQ-048 timeout_i=100, no capture: trigger_now_o pulses exactly once, 100 cycles after WAIT_TRIG entry; timeout_count_o=1; capture_done_i then completes normally.
REQ-049 abort_i in WAIT_TRIG: next cycle arm_o=0, busy_o=0, aborted_o=1, no done_o; a later start_i clears aborted_o.
REQ-050 capture_done_i in the timeout-expiry cycle (timeout_i=50): trigger_now_o stays 0, timeout_count_o=0, state WAIT_READ.
REQ-051 num_captures_i=0, 70000 captures: capture_count_o saturates at 65535 and the batch continues until abort.
REQ-052 Macro undefined, timeout_i=10: trigger_now_o never asserts and the block waits in WAIT_TRIG indefinitely.

Source files
------------

// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the capture sequencer: state encoding and default widths.
package capture_sequencer_pkg;

   localparam int unsigned COUNT_WIDTH_DEF   = 16;
   localparam int unsigned TIMEOUT_WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StArm       = 3'd1,
      StWaitArmed = 3'd2,
      StWaitTrig  = 3'd3,
      StWaitRead  = 3'd4,
      StFinish    = 3'd5
   } state_e;

endpackage

// File: rtl/capture_sequencer_timer.sv
// Trigger-timeout down-counter. Loaded on WAIT_TRIG entry, counts down while running and
// flags the cycle in which it holds 1. It stops at 0, so it fires at most once per load,
// and a load value of 0 means it never fires.
module capseq_timer
   import capture_sequencer_pkg::*;
#(
   parameter int unsigned pWIDTH = TIMEOUT_WIDTH_DEF
) (
   input  logic              clk_usb,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic [pWIDTH-1:0] i_value,
   input  logic              i_run,
   output logic              o_fire
);

   logic [pWIDTH-1:0] r_count;

   // Down-counter with clear > load > decrement priority.
   always_ff @(posedge clk_usb) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (i_run && (r_count != '0)) begin
         r_count <= r_count - pWIDTH'(1);
      end
   end

   assign o_fire = i_run && (r_count == pWIDTH'(1));

endmodule

// File: rtl/capture_sequencer.sv
// Capture batch sequencer: arms the trigger unit, counts captures, waits for host readout and
// optionally forces a trigger when the trigger wait exceeds timeout_i.
// Optional feature macro: CAPTURE_SEQUENCER_AUTO_TRIGGER_EN (timeout / forced trigger).
module capture_sequencer
   import capture_sequencer_pkg::*;
#(
   parameter int unsigned pCOUNT_WIDTH   = COUNT_WIDTH_DEF,
   parameter int unsigned pTIMEOUT_WIDTH = TIMEOUT_WIDTH_DEF
) (
   input  logic                      clk_usb,
   input  logic                      reset,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [pCOUNT_WIDTH-1:0]   num_captures_i,
   input  logic [pTIMEOUT_WIDTH-1:0] timeout_i,
   input  logic                      armed_i,
   input  logic                      capture_done_i,
   input  logic                      readout_done_i,
   output logic                      arm_o,
   output logic                      trigger_now_o,
   output logic                      busy_o,
   output logic [pCOUNT_WIDTH-1:0]   capture_count_o,
   output logic [pCOUNT_WIDTH-1:0]   timeout_count_o,
   output logic                      done_o,
   output logic                      aborted_o
);

   state_e                  r_state;
   logic                    r_arm;
   logic                    r_trig;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_aborted;
   logic [pCOUNT_WIDTH-1:0] r_cap_cnt;
   logic [pCOUNT_WIDTH-1:0] r_to_cnt;
   logic                    w_fire;
   logic                    w_last_capture;

`ifdef CAPTURE_SEQUENCER_AUTO_TRIGGER_EN
   logic w_timer_load;
   logic w_timer_run;

   assign w_timer_load = (r_state == StWaitArmed) && armed_i;
   assign w_timer_run  = (r_state == StWaitTrig);

   capseq_timer #(
      .pWIDTH (pTIMEOUT_WIDTH)
   ) u_timer (
      .clk_usb (clk_usb),
      .reset   (reset),
      .i_clear (abort_i),
      .i_load  (w_timer_load),
      .i_value (timeout_i),
      .i_run   (w_timer_run),
      .o_fire  (w_fire)
   );
`else
   logic w_unused_timeout;

   assign w_unused_timeout = ^timeout_i;
   assign w_fire           = 1'b0;
`endif

   assign w_last_capture = (num_captures_i != '0) && (r_cap_cnt == num_captures_i);

   // Batch state machine; every output is a register updated here.
   always_ff @(posedge clk_usb) begin
      if (reset) begin
         r_state   <= StIdle;
         r_arm     <= 1'b0;
         r_trig    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         r_cap_cnt <= '0;
         r_to_cnt  <= '0;
      end else begin
         r_trig <= 1'b0;
         r_done <= 1'b0;
         if ((r_state != StIdle) && abort_i) begin
            // Abort overrides any event arriving in the same cycle.
            r_state   <= StIdle;
            r_arm     <= 1'b0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
         end else begin
            case (r_state)
               StIdle: begin
                  if (start_i) begin
                     r_cap_cnt <= '0;
                     r_to_cnt  <= '0;
                     r_aborted <= 1'b0;
                     r_busy    <= 1'b1;
                     r_state   <= StArm;
                  end
               end
               StArm: begin
                  r_arm   <= 1'b1;
                  r_state <= StWaitArmed;
               end
               StWaitArmed: begin
                  if (armed_i) begin
                     r_state <= StWaitTrig;
                  end
               end
               StWaitTrig: begin
                  if (capture_done_i) begin
                     // A capture in the expiry cycle suppresses the forced trigger.
                     if (!(&r_cap_cnt)) begin
                        r_cap_cnt <= r_cap_cnt + pCOUNT_WIDTH'(1);
                     end
                     r_arm   <= 1'b0;
                     r_state <= StWaitRead;
                  end else if (w_fire) begin
                     r_trig <= 1'b1;
                     if (!(&r_to_cnt)) begin
                        r_to_cnt <= r_to_cnt + pCOUNT_WIDTH'(1);
                     end
                  end
               end
               StWaitRead: begin
                  if (readout_done_i) begin
                     r_state <= w_last_capture ? StFinish : StArm;
                  end
               end
               StFinish: begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end
               default: begin
                  r_state <= StIdle;
                  r_arm   <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign arm_o           = r_arm;
   assign trigger_now_o   = r_trig;
   assign busy_o          = r_busy;
   assign done_o          = r_done;
   assign aborted_o       = r_aborted;
   assign capture_count_o = r_cap_cnt;
   assign timeout_count_o = r_to_cnt;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer. Uses an 8-bit count width so that saturation
// is reachable in a short run. Timeout tests follow CAPTURE_SEQUENCER_AUTO_TRIGGER_EN.
module tb_capture_sequencer;

   localparam int unsigned CW = 8;
   localparam int unsigned TW = 32;

   logic          clk_usb = 1'b0;
   logic          reset;
   logic          start_i;
   logic          abort_i;
   logic [CW-1:0] num_captures_i;
   logic [TW-1:0] timeout_i;
   logic          armed_i;
   logic          capture_done_i;
   logic          readout_done_i;
   logic          arm_o;
   logic          trigger_now_o;
   logic          busy_o;
   logic [CW-1:0] capture_count_o;
   logic [CW-1:0] timeout_count_o;
   logic          done_o;
   logic          aborted_o;

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   capture_sequencer #(
      .pCOUNT_WIDTH   (CW),
      .pTIMEOUT_WIDTH (TW)
   ) dut (
      .clk_usb         (clk_usb),
      .reset           (reset),
      .start_i         (start_i),
      .abort_i         (abort_i),
      .num_captures_i  (num_captures_i),
      .timeout_i       (timeout_i),
      .armed_i         (armed_i),
      .capture_done_i  (capture_done_i),
      .readout_done_i  (readout_done_i),
      .arm_o           (arm_o),
      .trigger_now_o   (trigger_now_o),
      .busy_o          (busy_o),
      .capture_count_o (capture_count_o),
      .timeout_count_o (timeout_count_o),
      .done_o          (done_o),
      .aborted_o       (aborted_o)
   );

   always #5 clk_usb = ~clk_usb;

   // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_usb);
         #1;
      end
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      cyc(1);
      start_i = 1'b0;
   endtask

   task automatic pulse_abort();
      abort_i = 1'b1;
      cyc(1);
      abort_i = 1'b0;
   endtask

   task automatic pulse_readout();
      readout_done_i = 1'b1;
      cyc(1);
      readout_done_i = 1'b0;
   endtask

   // Bounded wait for arm_o to go high.
   task automatic wait_arm(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (arm_o) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(3);
      total++; if (arm_o !== 1'b0) begin bad++; $display("FAIL rst_arm got %b want 0", arm_o); end
      total++; if (trigger_now_o !== 1'b0) begin bad++; $display("FAIL rst_trig got %b want 0", trigger_now_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy_o); end
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done_o); end
      total++; if (aborted_o !== 1'b0) begin bad++; $display("FAIL rst_aborted got %b want 0", aborted_o); end
      total++; if (capture_count_o !== '0) begin bad++; $display("FAIL rst_capcnt got %0d want 0", capture_count_o); end
      total++; if (timeout_count_o !== '0) begin bad++; $display("FAIL rst_tocnt got %0d want 0", timeout_count_o); end
      reset = 1'b0;
      cyc(2);
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_busy got %b want 0", busy_o); end
   endtask

   // Three-capture batch with no timeout; a start pulse while busy must be ignored.
   task automatic test_batch();
      bit ok;
      int arm_rises = 0;
      int done_cnt  = 0;
      logic [CW-1:0] e_cnt;
      num_captures_i = CW'(3);
      timeout_i      = '0;
      armed_i        = 1'b1;
      pulse_start();
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL batch_busy got %b want 1", busy_o); end
      for (int k = 0; k < 3; k++) begin
         wait_arm(ok);
         total++; if (!ok) begin bad++; $display("FAIL batch_arm_wait got 0 want 1 (capture %0d)", k); end
         if (ok) arm_rises++;
         cyc(1);
         capture_done_i = 1'b1;
         exp_q.push_back(k + 1);
         cyc(1);
         capture_done_i = 1'b0;
         e_cnt = CW'(exp_q.pop_front());
         total++; if (capture_count_o !== e_cnt) begin bad++; $display("FAIL batch_capcnt got %0d want %0d", capture_count_o, e_cnt); end
         total++; if (arm_o !== 1'b0) begin bad++; $display("FAIL batch_arm_drop got %b want 0", arm_o); end
         if (k == 0) begin
            pulse_start();
            total++; if (capture_count_o !== CW'(1)) begin bad++; $display("FAIL busy_start_ignored got %0d want 1", capture_count_o); end
         end
         pulse_readout();
      end
      for (int i = 0; i < 5; i++) begin
         if (done_o) done_cnt++;
         cyc(1);
      end
      total++; if (arm_rises != 3) begin bad++; $display("FAIL batch_arm_count got %0d want 3", arm_rises); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL batch_done_pulses got %0d want 1", done_cnt); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL batch_end_busy got %b want 0", busy_o); end
      total++; if (capture_count_o !== CW'(3)) begin bad++; $display("FAIL batch_final_cnt got %0d want 3", capture_count_o); end
   endtask

   // Stray events are ignored; abort behaviour and priorities.
   task automatic test_abort();
      int done_cnt = 0;
      num_captures_i = CW'(2);
      timeout_i      = '0;
      armed_i        = 1'b0;
      pulse_start();
      cyc(1);
      capture_done_i = 1'b1;
      cyc(1);
      capture_done_i = 1'b0;
      total++; if (capture_count_o !== '0) begin bad++; $display("FAIL stray_capture got %0d want 0", capture_count_o); end
      pulse_readout();
      total++; if (arm_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL stray_readout got arm=%b busy=%b want 1 1", arm_o, busy_o); end
      armed_i = 1'b1;
      cyc(1);
      pulse_readout();
      total++; if (arm_o !== 1'b1) begin bad++; $display("FAIL trig_readout_ignored got %b want 1", arm_o); end
      pulse_abort();
      total++; if (arm_o !== 1'b0) begin bad++; $display("FAIL abort_arm got %b want 0", arm_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", busy_o); end
      total++; if (aborted_o !== 1'b1) begin bad++; $display("FAIL abort_flag got %b want 1", aborted_o); end
      for (int i = 0; i < 4; i++) begin
         if (done_o) done_cnt++;
         cyc(1);
      end
      total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_done got %0d want 0", done_cnt); end
      total++; if (aborted_o !== 1'b1) begin bad++; $display("FAIL abort_sticky got %b want 1", aborted_o); end
      // Start and abort together in IDLE: start wins.
      start_i = 1'b1;
      abort_i = 1'b1;
      cyc(1);
      start_i = 1'b0;
      abort_i = 1'b0;
      total++; if (busy_o !== 1'b1 || aborted_o !== 1'b0) begin bad++; $display("FAIL start_wins got busy=%b aborted=%b want 1 0", busy_o, aborted_o); end
      // Abort with a simultaneous capture in WAIT_TRIG: abort wins.
      cyc(2);
      capture_done_i = 1'b1;
      abort_i        = 1'b1;
      cyc(1);
      capture_done_i = 1'b0;
      abort_i        = 1'b0;
      total++; if (capture_count_o !== '0 || aborted_o !== 1'b1 || busy_o !== 1'b0) begin
         bad++;
         $display("FAIL abort_priority got cnt=%0d aborted=%b busy=%b want 0 1 0", capture_count_o, aborted_o, busy_o);
      end
   endtask

   // Reset in the middle of a batch acts like abort but leaves aborted_o low.
   task automatic test_reset_midbatch();
      armed_i = 1'b1;
      pulse_start();
      total++; if (aborted_o !== 1'b0) begin bad++; $display("FAIL start_clears_aborted got %b want 0", aborted_o); end
      cyc(2);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      total++; if (arm_o !== 1'b0 || busy_o !== 1'b0 || aborted_o !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got arm=%b busy=%b aborted=%b want 0 0 0", arm_o, busy_o, aborted_o);
      end
   endtask

   // Continuous mode: counter saturates at all-ones and the batch keeps running.
   task automatic test_saturate();
      bit ok;
      logic [CW-1:0] e_cnt;
      num_captures_i = '0;
      timeout_i      = '0;
      armed_i        = 1'b1;
      pulse_start();
      for (int i = 1; i <= 300; i++) begin
         wait_arm(ok);
         total++; if (!ok) begin bad++; $display("FAIL sat_arm_wait got 0 want 1 (capture %0d)", i); end
         cyc(1);
         capture_done_i = 1'b1;
         exp_q.push_back((i > 255) ? 255 : i);
         cyc(1);
         capture_done_i = 1'b0;
         e_cnt = CW'(exp_q.pop_front());
         total++; if (capture_count_o !== e_cnt) begin bad++; $display("FAIL sat_capcnt got %0d want %0d", capture_count_o, e_cnt); end
         pulse_readout();
      end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL sat_still_busy got %b want 1", busy_o); end
      total++; if (timeout_count_o !== '0) begin bad++; $display("FAIL sat_tocnt got %0d want 0", timeout_count_o); end
      pulse_abort();
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL sat_abort got %b want 0", busy_o); end
   endtask

`ifdef CAPTURE_SEQUENCER_AUTO_TRIGGER_EN
   // Forced trigger exactly timeout_i cycles after WAIT_TRIG entry, only once.
   task automatic test_timeout();
      int first  = -1;
      int pulses = 0;
      int done_cnt = 0;
      num_captures_i = CW'(1);
      timeout_i      = TW'(100);
      armed_i        = 1'b1;
      pulse_start();
      cyc(2);
      for (int k = 1; k <= 150; k++) begin
         cyc(1);
         if (trigger_now_o) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      total++; if (first != 100) begin bad++; $display("FAIL to_first got %0d want 100", first); end
      total++; if (pulses != 1) begin bad++; $display("FAIL to_pulses got %0d want 1", pulses); end
      total++; if (timeout_count_o !== CW'(1)) begin bad++; $display("FAIL to_count got %0d want 1", timeout_count_o); end
      total++; if (arm_o !== 1'b1) begin bad++; $display("FAIL to_still_waiting got %b want 1", arm_o); end
      capture_done_i = 1'b1;
      cyc(1);
      capture_done_i = 1'b0;
      total++; if (capture_count_o !== CW'(1)) begin bad++; $display("FAIL to_capcnt got %0d want 1", capture_count_o); end
      pulse_readout();
      for (int i = 0; i < 4; i++) begin
         if (done_o) done_cnt++;
         cyc(1);
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL to_done got %0d want 1", done_cnt); end
   endtask

   // Capture in the expiry cycle wins over the forced trigger.
   task automatic test_capture_wins();
      int pulses = 0;
      num_captures_i = CW'(2);
      timeout_i      = TW'(50);
      armed_i        = 1'b1;
      pulse_start();
      cyc(2);
      cyc(49);
      capture_done_i = 1'b1;
      cyc(1);
      capture_done_i = 1'b0;
      total++; if (trigger_now_o !== 1'b0) begin bad++; $display("FAIL cw_trig got %b want 0", trigger_now_o); end
      total++; if (timeout_count_o !== '0) begin bad++; $display("FAIL cw_tocnt got %0d want 0", timeout_count_o); end
      total++; if (arm_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL cw_state got arm=%b busy=%b want 0 1", arm_o, busy_o); end
      total++; if (capture_count_o !== CW'(1)) begin bad++; $display("FAIL cw_capcnt got %0d want 1", capture_count_o); end
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         if (trigger_now_o) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL cw_late_trig got %0d want 0", pulses); end
      pulse_abort();
   endtask
`else
   // Without the feature the block waits in WAIT_TRIG indefinitely.
   task automatic test_no_timeout();
      int pulses = 0;
      num_captures_i = CW'(1);
      timeout_i      = TW'(10);
      armed_i        = 1'b1;
      pulse_start();
      cyc(2);
      for (int k = 0; k < 200; k++) begin
         cyc(1);
         if (trigger_now_o) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL nt_trig got %0d want 0", pulses); end
      total++; if (timeout_count_o !== '0) begin bad++; $display("FAIL nt_tocnt got %0d want 0", timeout_count_o); end
      total++; if (arm_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL nt_waiting got arm=%b busy=%b want 1 1", arm_o, busy_o); end
      pulse_abort();
   endtask
`endif

   initial begin
      reset          = 1'b1;
      start_i        = 1'b0;
      abort_i        = 1'b0;
      num_captures_i = '0;
      timeout_i      = '0;
      armed_i        = 1'b0;
      capture_done_i = 1'b0;
      readout_done_i = 1'b0;
      test_reset();
      test_batch();
      test_abort();
      test_reset_midbatch();
      test_saturate();
`ifdef CAPTURE_SEQUENCER_AUTO_TRIGGER_EN
      test_timeout();
      test_capture_wins();
`else
      test_no_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
